// File: rtl/ram_arbiter_fsm.sv
// Arbitrates a fetch port and a data port onto one shared multi-cycle RAM port.
// Data wins by default; a saturating starvation counter forces a fetch grant.
module ram_arbiter_fsm #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_TIMEOUT  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_load,
  output logic              ihit,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_store,
  input  logic [1:0]        dmem_width,
  output logic [DATA_W-1:0] dmem_load,
  output logic              dhit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic [1:0]        ram_width,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              mem_err,
  output logic [1:0]        dbg_state_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(RAM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IBUSY = 2'd1,
    S_DBUSY = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     starve_q;
  logic [TW-1:0]     tmo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [1:0]        width_q;
  logic              ren_q;
  logic              wen_q;
  logic              ihit_q;
  logic              dhit_q;
  logic              err_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;

  logic              dgrant_d;
  logic [SW-1:0]     starve_d;

  // Data is granted unless fetch is pending and has already been passed over STARVE_LIMIT times.
  always_comb begin
    dgrant_d = (dmem_wen | dmem_ren) &&
               !(imem_ren && (starve_q == SW'(STARVE_LIMIT)));
    starve_d = '0;
    if (imem_ren) begin
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      width_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      err_q    <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (dgrant_d) begin
            state_q  <= S_DBUSY;
            addr_q   <= dmem_addr;
            store_q  <= dmem_store;
            width_q  <= dmem_width;
            wen_q    <= dmem_wen;
            ren_q    <= !dmem_wen;
            starve_q <= starve_d;
          end else if (imem_ren) begin
            state_q  <= S_IBUSY;
            addr_q   <= imem_addr;
            store_q  <= '0;
            width_q  <= 2'b10;
            wen_q    <= 1'b0;
            ren_q    <= 1'b1;
            starve_q <= '0;
          end
        end
        S_IBUSY, S_DBUSY: begin
          if (ram_ready || (tmo_q == TW'(RAM_TIMEOUT - 1))) begin
            // Timed-out and store accesses both return zero on the load port.
            state_q <= S_RESP;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= !ram_ready;
            if (state_q == S_IBUSY) begin
              ihit_q  <= 1'b1;
              iload_q <= ram_ready ? ram_load : '0;
            end else begin
              dhit_q  <= 1'b1;
              dload_q <= (ram_ready && !wen_q) ? ram_load : '0;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RESP: begin
          tmo_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_addr    = addr_q;
  assign ram_store   = store_q;
  assign ram_width   = width_q;
  assign ram_ren     = ren_q;
  assign ram_wen     = wen_q;
  assign ihit        = ihit_q;
  assign dhit        = dhit_q;
  assign mem_err     = err_q;
  assign imem_load   = iload_q;
  assign dmem_load   = dload_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter_fsm.sv
// Bench for ram_arbiter_fsm: directed vector table, corner sequences and randomized traffic.
module tb_ram_arbiter_fsm;

  logic        CLK;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_load;
  logic        ihit;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_store;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_load;
  logic        dhit;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [1:0]  ram_width;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        mem_err;
  logic [1:0]  dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // RAM responder: raises ready in busy cycle ram_lat (1-based); 0 means never.
  int          ram_lat  = 1;
  logic [31:0] ram_data = '0;
  int          bcnt;

  ram_arbiter_fsm dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width), .dmem_load(dmem_load), .dhit(dhit),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_width(ram_width),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_load(ram_load), .ram_ready(ram_ready),
    .mem_err(mem_err), .dbg_state_o(dbg_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) bcnt <= 0;
    else if (ram_ren || ram_wen) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  assign ram_ready = (ram_ren || ram_wen) && (ram_lat != 0) && (bcnt == ram_lat - 1);
  assign ram_load  = ram_data;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic clear_req();
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
  endtask

  // Called in IDLE with requests already driven; returns in the hit (RESP) cycle.
  task automatic serve(input string tag, input bit exp_fetch, input bit exp_wen,
                       input logic [31:0] exp_addr, input logic [31:0] exp_store,
                       input logic [1:0] exp_width, input int exp_busy,
                       input bit exp_err, input logic [31:0] exp_load);
    int busy;
    bit stable;
    bit quiet;
    busy   = 0;
    stable = 1'b1;
    quiet  = 1'b1;
    tick();
    chk1({tag, " ram_ren"}, ram_ren, !exp_wen);
    chk1({tag, " ram_wen"}, ram_wen, exp_wen);
    chk32({tag, " ram_addr"}, ram_addr, exp_addr);
    chk32({tag, " ram_width"}, {30'd0, ram_width}, {30'd0, exp_width});
    if (exp_wen) chk32({tag, " ram_store"}, ram_store, exp_store);
    while ((ram_ren || ram_wen) && busy < 40) begin
      busy++;
      if (ram_addr !== exp_addr || ram_ren !== !exp_wen || ram_wen !== exp_wen ||
          ram_width !== exp_width) stable = 1'b0;
      if (ihit || dhit || mem_err) quiet = 1'b0;
      tick();
    end
    chk32({tag, " busy_cycles"}, busy, exp_busy);
    chk1({tag, " strobes_stable"}, stable, 1'b1);
    chk1({tag, " no_early_hit"}, quiet, 1'b1);
    chk1({tag, " ihit"}, ihit, exp_fetch);
    chk1({tag, " dhit"}, dhit, !exp_fetch);
    chk1({tag, " mem_err"}, mem_err, exp_err);
    chk32({tag, " load"}, exp_fetch ? imem_load : dmem_load, exp_load);
  endtask

  typedef struct {
    bit          fetch;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [1:0]  width;
    int          lat;
    logic [31:0] rdata;
    int          exp_busy;
    bit          exp_err;
    logic [1:0]  exp_width;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[7];

  // Reference model state for randomized traffic.
  bit          fpend, dpend, dwen_m;
  logic [31:0] faddr_m, daddr_m, dstore_m;
  logic [1:0]  dwidth_m;
  int          starve_m;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h100,  32'h0,        2'b00, 2, 32'hDEADBEEF, 2,  1'b0, 2'b10, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h2000, 32'h55,       2'b00, 1, 32'hFFFFFFFF, 1,  1'b0, 2'b00, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h40,   32'h0,        2'b01, 3, 32'h00001234, 3,  1'b0, 2'b01, 32'h00001234};
    vecs[3] = '{1'b0, 1'b0, 32'h300,  32'h0,        2'b10, 0, 32'h77,       16, 1'b1, 2'b10, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h400,  32'h0,        2'b00, 0, 32'h88,       16, 1'b1, 2'b10, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'h800,  32'hA5A5A5A5, 2'b10, 0, 32'h0,        16, 1'b1, 2'b10, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h900,  32'h0,        2'b00, 4, 32'h5A5A5A5A, 4,  1'b0, 2'b00, 32'h5A5A5A5A};

    nRST = 1'b0;
    clear_req();
    imem_addr  = '0;
    dmem_addr  = '0;
    dmem_store = '0;
    dmem_width = '0;
    tick();
    tick();
    chk32("reset state", {30'd0, dbg_state}, 32'd0);
    chk1("reset ram_ren", ram_ren, 1'b0);
    chk1("reset ram_wen", ram_wen, 1'b0);
    chk32("reset ram_addr", ram_addr, 32'h0);
    chk1("reset hits", ihit | dhit | mem_err, 1'b0);
    chk32("reset loads", imem_load | dmem_load, 32'h0);
    nRST = 1'b1;
    tick();

    // Directed vector table, one requester at a time.
    for (int i = 0; i < 7; i++) begin
      imem_ren   = vecs[i].fetch;
      imem_addr  = vecs[i].addr;
      dmem_ren   = !vecs[i].fetch && !vecs[i].wen;
      dmem_wen   = !vecs[i].fetch && vecs[i].wen;
      dmem_addr  = vecs[i].addr;
      dmem_store = vecs[i].store;
      dmem_width = vecs[i].width;
      ram_lat    = vecs[i].lat;
      ram_data   = vecs[i].rdata;
      serve($sformatf("vec%0d", i), vecs[i].fetch, vecs[i].wen, vecs[i].addr, vecs[i].store,
            vecs[i].exp_width, vecs[i].exp_busy, vecs[i].exp_err, vecs[i].exp_load);
      clear_req();
      tick();
    end

    // Both ports held: four data grants, then a forced fetch, twice over.
    imem_ren   = 1'b1;
    imem_addr  = 32'h1000;
    dmem_ren   = 1'b1;
    dmem_addr  = 32'h2000;
    dmem_width = 2'b10;
    ram_lat    = 1;
    for (int g = 0; g < 10; g++) begin
      ram_data = 32'hC0DE0000 + g;
      if (g % 5 == 4)
        serve($sformatf("arb%0d", g), 1'b1, 1'b0, 32'h1000, 32'h0, 2'b10, 1, 1'b0, ram_data);
      else
        serve($sformatf("arb%0d", g), 1'b0, 1'b0, 32'h2000, 32'h0, 2'b10, 1, 1'b0, ram_data);
      tick();
    end
    clear_req();
    tick();

    // Datapath address changes mid-access must not reach the RAM.
    dmem_ren  = 1'b1;
    dmem_addr = 32'h40;
    ram_lat   = 5;
    ram_data  = 32'h13579BDF;
    tick();
    chk32("hold addr busy1", ram_addr, 32'h40);
    tick();
    dmem_addr = 32'h80;
    for (int c = 2; c <= 5; c++) begin
      chk32($sformatf("hold addr busy%0d", c), ram_addr, 32'h40);
      tick();
    end
    chk1("hold addr dhit", dhit, 1'b1);
    chk32("hold addr load", dmem_load, 32'h13579BDF);
    clear_req();
    tick();

    // Asynchronous reset in the third busy cycle of a load.
    begin
      bit seen_hit;
      dmem_ren  = 1'b1;
      dmem_addr = 32'h500;
      ram_lat   = 0;
      tick();
      tick();
      tick();
      chk1("abort strobe before reset", ram_ren, 1'b1);
      #2 nRST = 1'b0;
      #1;
      chk1("abort ram_ren", ram_ren, 1'b0);
      chk1("abort ram_wen", ram_wen, 1'b0);
      clear_req();
      tick();
      nRST = 1'b1;
      seen_hit = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (ihit || dhit || ram_ren || ram_wen) seen_hit = 1'b1;
      end
      chk1("abort no hit after release", seen_hit, 1'b0);
      imem_ren  = 1'b1;
      imem_addr = 32'h600;
      ram_lat   = 1;
      ram_data  = 32'hCAFEF00D;
      serve("post-reset fetch", 1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 1, 1'b0, 32'hCAFEF00D);
      clear_req();
      tick();
    end

    // Randomized traffic against the arbitration rules.
    fpend    = 1'b0;
    dpend    = 1'b0;
    starve_m = 0;
    for (int it = 0; it < 60; it++) begin
      bit          gd;
      int          eb;
      bit          ee;
      logic [31:0] el;
      if (!fpend && $urandom_range(0, 1) == 1) begin
        fpend   = 1'b1;
        faddr_m = $urandom & 32'hFFFFFFFC;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend    = 1'b1;
        dwen_m   = $urandom_range(0, 1) == 1;
        daddr_m  = $urandom;
        dstore_m = $urandom;
        dwidth_m = 2'($urandom_range(0, 2));
      end
      imem_ren   = fpend;
      imem_addr  = faddr_m;
      dmem_wen   = dpend && dwen_m;
      dmem_ren   = dpend && (dwen_m ? ($urandom_range(0, 1) == 1) : 1'b1);
      dmem_addr  = daddr_m;
      dmem_store = dstore_m;
      dmem_width = dwidth_m;
      ram_lat    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      ram_data   = $urandom;
      if (!fpend && !dpend) begin
        tick();
        chk1($sformatf("rnd%0d idle strobes", it), ram_ren | ram_wen, 1'b0);
        continue;
      end
      gd = dpend && !(fpend && starve_m >= 4);
      if (gd) starve_m = fpend ? ((starve_m + 1 > 4) ? 4 : starve_m + 1) : 0;
      else starve_m = 0;
      ee = (ram_lat == 0);
      eb = ee ? 16 : ram_lat;
      el = (ee || (gd && dwen_m)) ? 32'h0 : ram_data;
      if (gd)
        serve($sformatf("rnd%0d data", it), 1'b0, dwen_m, daddr_m, dstore_m, dwidth_m, eb, ee, el);
      else
        serve($sformatf("rnd%0d fetch", it), 1'b1, 1'b0, faddr_m, 32'h0, 2'b10, eb, ee, el);
      if (gd) begin
        dpend    = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
      end else begin
        fpend    = 1'b0;
        imem_ren = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
